// File: rtl/i_imm_pkg.sv
// Shared constants for the I-format immediate control unit: opcodes, ALU
// function codes, PC select encoding and FSM state encodings.
package i_imm_pkg;

    localparam logic [9:0] OP_ADDI  = 10'b1001000100;
    localparam logic [9:0] OP_ADDIS = 10'b1011000100;
    localparam logic [9:0] OP_SUBI  = 10'b1101000100;
    localparam logic [9:0] OP_SUBIS = 10'b1111000100;
    localparam logic [9:0] OP_ANDI  = 10'b1001001000;
    localparam logic [9:0] OP_ANDIS = 10'b1111001000;
    localparam logic [9:0] OP_ORRI  = 10'b1011001000;
    localparam logic [9:0] OP_EORI  = 10'b1101001000;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_EOR = 5'b01100;

    localparam logic [1:0] PS_INC = 2'b01;
    localparam logic [4:0] XZR    = 5'd31;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

endpackage

// File: rtl/i_imm_decode.sv
// Pure combinational decode of one I-format instruction into control-word
// fields. Unsupported opcodes yield a harmless word flagged as illegal.
module i_imm_decode
    import i_imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 12
) (
    input  logic [31:0]       instr_i,
    output logic [4:0]        da_o,
    output logic [4:0]        sa_o,
    output logic [4:0]        sb_o,
    output logic [4:0]        fs_o,
    output logic [1:0]        ps_o,
    output logic              reg_write_o,
    output logic              mem_write_o,
    output logic              pc_sel_o,
    output logic              b_sel_o,
    output logic              status_load_o,
    output logic [DATA_W-1:0] k_o,
    output logic              illegal_o
);

    logic [9:0] opcode;
    logic       legal;
    logic [4:0] fs;
    logic       sets_flags;

    assign opcode = instr_i[31:22];

    always_comb begin
        legal      = 1'b1;
        fs         = FS_AND;
        sets_flags = 1'b0;
        case (opcode)
            OP_ADDI:  fs = FS_ADD;
            OP_ADDIS: begin fs = FS_ADD; sets_flags = 1'b1; end
            OP_SUBI:  fs = FS_SUB;
            OP_SUBIS: begin fs = FS_SUB; sets_flags = 1'b1; end
            OP_ANDI:  fs = FS_AND;
            OP_ANDIS: begin fs = FS_AND; sets_flags = 1'b1; end
            OP_ORRI:  fs = FS_ORR;
            OP_EORI:  fs = FS_EOR;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        da_o          = instr_i[4:0];
        sa_o          = instr_i[9:5];
        sb_o          = 5'd0;
        ps_o          = PS_INC;
        pc_sel_o      = 1'b0;
        mem_write_o   = 1'b0;
        b_sel_o       = 1'b1;
        fs_o          = legal ? fs : 5'd0;
        status_load_o = legal && sets_flags;
        // Writes to XZR are dropped so the register file never sees them.
        reg_write_o   = legal && (instr_i[4:0] != XZR);
        illegal_o     = !legal;
        k_o           = '0;
        if (legal) begin
            k_o[IMM_W-1:0] = instr_i[10+IMM_W-1:10];
        end
    end

endmodule

// File: rtl/i_imm_ctrl_unit.sv
// Registered I-format decoder: one-entry output register with valid/ready on
// both sides, a two-state FSM and a counter of legal words consumed.
module i_imm_ctrl_unit
    import i_imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [31:0]       instr,
    output logic              instr_ready,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic [4:0]        DA,
    output logic [4:0]        SA,
    output logic [4:0]        SB,
    output logic [4:0]        FS,
    output logic [1:0]        PS,
    output logic              regWrite,
    output logic              memWrite,
    output logic              PC_sel,
    output logic              B_sel,
    output logic              status_load,
    output logic [DATA_W-1:0] k,
    output logic              state,
    output logic              illegal,
    output logic [CNT_W-1:0]  retired
);

    // Handshake: a transfer happens on a side only in a cycle where its valid
    // and ready are both high; instr_ready also lets a new word replace the
    // held one in the same cycle it is consumed, so there is no bubble.
    logic accept;
    logic consume;

    logic [0:0] state_q, state_d;

    logic [4:0]        dec_da, dec_sa, dec_sb, dec_fs;
    logic [1:0]        dec_ps;
    logic              dec_reg_write, dec_mem_write, dec_pc_sel, dec_b_sel;
    logic              dec_status_load, dec_illegal;
    logic [DATA_W-1:0] dec_k;

    logic [4:0]        da_q, sa_q, sb_q, fs_q;
    logic [1:0]        ps_q;
    logic              reg_write_q, mem_write_q, pc_sel_q, b_sel_q;
    logic              status_load_q, illegal_q;
    logic [DATA_W-1:0] k_q;
    logic [CNT_W-1:0]  retired_q;

    i_imm_decode #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_decode (
        .instr_i       (instr),
        .da_o          (dec_da),
        .sa_o          (dec_sa),
        .sb_o          (dec_sb),
        .fs_o          (dec_fs),
        .ps_o          (dec_ps),
        .reg_write_o   (dec_reg_write),
        .mem_write_o   (dec_mem_write),
        .pc_sel_o      (dec_pc_sel),
        .b_sel_o       (dec_b_sel),
        .status_load_o (dec_status_load),
        .k_o           (dec_k),
        .illegal_o     (dec_illegal)
    );

    assign cw_valid    = (state_q == ST_HOLD);
    assign instr_ready = !cw_valid || cw_ready;
    assign accept      = instr_valid && instr_ready;
    assign consume     = cw_valid && cw_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_HOLD;
            ST_HOLD: if (consume && !accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            da_q          <= '0;
            sa_q          <= '0;
            sb_q          <= '0;
            fs_q          <= '0;
            ps_q          <= '0;
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            pc_sel_q      <= 1'b0;
            b_sel_q       <= 1'b0;
            status_load_q <= 1'b0;
            illegal_q     <= 1'b0;
            k_q           <= '0;
            retired_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                da_q          <= dec_da;
                sa_q          <= dec_sa;
                sb_q          <= dec_sb;
                fs_q          <= dec_fs;
                ps_q          <= dec_ps;
                reg_write_q   <= dec_reg_write;
                mem_write_q   <= dec_mem_write;
                pc_sel_q      <= dec_pc_sel;
                b_sel_q       <= dec_b_sel;
                status_load_q <= dec_status_load;
                illegal_q     <= dec_illegal;
                k_q           <= dec_k;
            end
            if (consume && !illegal_q) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign DA          = da_q;
    assign SA          = sa_q;
    assign SB          = sb_q;
    assign FS          = fs_q;
    assign PS          = ps_q;
    assign regWrite    = reg_write_q;
    assign memWrite    = mem_write_q;
    assign PC_sel      = pc_sel_q;
    assign B_sel       = b_sel_q;
    assign status_load = status_load_q;
    assign k           = k_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;
    assign state       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_i_imm_ctrl_unit.sv
// Directed bench for i_imm_ctrl_unit; a second instance with a 4-bit counter
// shares the stimulus to exercise counter wrap.
module tb_i_imm_ctrl_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        cw_ready = 1'b0;

    logic        instr_ready, cw_valid;
    logic [4:0]  DA, SA, SB, FS;
    logic [1:0]  PS;
    logic        regWrite, memWrite, PC_sel, B_sel, status_load, state, illegal;
    logic [63:0] k;
    logic [15:0] retired;

    logic        instr_ready4, cw_valid4;
    logic [4:0]  da4, sa4, sb4, fs4;
    logic [1:0]  ps4;
    logic        rw4, mw4, pcs4, bs4, sl4, st4, ill4;
    logic [63:0] k4;
    logic [3:0]  retired4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    i_imm_ctrl_unit #(.DATA_W(64), .IMM_W(12), .CNT_W(16)) u_dut (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .cw_valid(cw_valid), .cw_ready(cw_ready),
        .DA(DA), .SA(SA), .SB(SB), .FS(FS), .PS(PS), .regWrite(regWrite),
        .memWrite(memWrite), .PC_sel(PC_sel), .B_sel(B_sel),
        .status_load(status_load), .k(k), .state(state), .illegal(illegal),
        .retired(retired)
    );

    i_imm_ctrl_unit #(.DATA_W(64), .IMM_W(12), .CNT_W(4)) u_dut4 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready4), .cw_valid(cw_valid4), .cw_ready(cw_ready),
        .DA(da4), .SA(sa4), .SB(sb4), .FS(fs4), .PS(ps4), .regWrite(rw4),
        .memWrite(mw4), .PC_sel(pcs4), .B_sel(bs4),
        .status_load(sl4), .k(k4), .state(st4), .illegal(ill4),
        .retired(retired4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [9:0] op, input logic [11:0] imm,
                                       input logic [4:0] rn, input logic [4:0] rd);
        return {op, imm, rn, rd};
    endfunction

    // Advance to just after the next active edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // 1. reset held with a valid instruction offered
        instr_valid = 1'b1;
        instr       = mk(10'b1001000100, 12'd1, 5'd0, 5'd1);
        cw_ready    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_cw_valid", cw_valid, 0);
            check("rst_state", state, 0);
            check("rst_retired", retired, 0);
            check("rst_instr_ready", instr_ready, 1);
            check("rst_k", k, 0);
        end
        instr_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();
        check("idle_cw_valid", cw_valid, 0);

        // 2. ADDI X1, X0, #1
        instr_valid = 1'b1;
        instr       = mk(10'b1001000100, 12'd1, 5'd0, 5'd1);
        cw_ready    = 1'b1;
        step();
        instr_valid = 1'b0;
        check("addi_cw_valid", cw_valid, 1);
        check("addi_state", state, 1);
        check("addi_DA", DA, 1);
        check("addi_SA", SA, 0);
        check("addi_SB", SB, 0);
        check("addi_FS", FS, 5'b01000);
        check("addi_PS", PS, 2'b01);
        check("addi_k", k, 1);
        check("addi_regWrite", regWrite, 1);
        check("addi_memWrite", memWrite, 0);
        check("addi_PC_sel", PC_sel, 0);
        check("addi_B_sel", B_sel, 1);
        check("addi_status_load", status_load, 0);
        check("addi_illegal", illegal, 0);
        check("addi_retired_pre", retired, 0);
        step();
        check("addi_retired", retired, 1);
        check("addi_idle", cw_valid, 0);

        // 3. SUBIS X7, X6, #8 held by back-pressure; instr changes must be ignored
        instr_valid = 1'b1;
        instr       = mk(10'b1111000100, 12'd8, 5'd6, 5'd7);
        cw_ready    = 1'b0;
        step();
        instr = mk(10'b1001001000, 12'hABC, 5'd9, 5'd9);
        for (int i = 0; i < 3; i++) begin
            check("subis_instr_ready", instr_ready, 0);
            check("subis_DA", DA, 7);
            check("subis_SA", SA, 6);
            check("subis_FS", FS, 5'b01001);
            check("subis_k", k, 8);
            check("subis_status_load", status_load, 1);
            check("subis_retired_hold", retired, 1);
            step();
        end
        cw_ready    = 1'b1;
        instr_valid = 1'b0;
        #1;
        check("subis_ready_release", instr_ready, 1);
        step();
        check("subis_retired", retired, 2);
        check("subis_idle", state, 0);

        // 4. back-to-back SUBI / ADDIS / ORRI
        instr_valid = 1'b1;
        instr       = mk(10'b1101000100, 12'd5, 5'd3, 5'd2);
        step();
        check("b2b_subi_DA", DA, 2);
        check("b2b_subi_FS", FS, 5'b01001);
        check("b2b_subi_sl", status_load, 0);
        check("b2b_subi_state", state, 1);
        instr = mk(10'b1011000100, 12'hFFF, 5'd1, 5'd4);
        step();
        check("b2b_addis_DA", DA, 4);
        check("b2b_addis_FS", FS, 5'b01000);
        check("b2b_addis_k", k, 64'hFFF);
        check("b2b_addis_sl", status_load, 1);
        check("b2b_addis_state", state, 1);
        check("b2b_addis_retired", retired, 3);
        instr = mk(10'b1011001000, 12'h0A5, 5'd8, 5'd5);
        step();
        check("b2b_orri_DA", DA, 5);
        check("b2b_orri_FS", FS, 5'b00100);
        check("b2b_orri_k", k, 64'hA5);
        check("b2b_orri_state", state, 1);
        check("b2b_orri_retired", retired, 4);
        instr_valid = 1'b0;
        step();
        check("b2b_retired", retired, 5);
        check("b2b_idle", state, 0);

        // 5. ADDI to XZR, then an unsupported opcode
        instr_valid = 1'b1;
        instr       = mk(10'b1001000100, 12'd3, 5'd2, 5'd31);
        step();
        check("xzr_DA", DA, 31);
        check("xzr_regWrite", regWrite, 0);
        check("xzr_illegal", illegal, 0);
        instr = mk(10'b1111111111, 12'h123, 5'd4, 5'd3);
        step();
        check("xzr_retired", retired, 6);
        check("ill_illegal", illegal, 1);
        check("ill_regWrite", regWrite, 0);
        check("ill_memWrite", memWrite, 0);
        check("ill_status_load", status_load, 0);
        check("ill_FS", FS, 0);
        check("ill_k", k, 0);
        check("ill_cw_valid", cw_valid, 1);
        instr_valid = 1'b0;
        step();
        check("ill_retired", retired, 6);

        // EORI and ANDIS decode
        instr_valid = 1'b1;
        instr       = mk(10'b1101001000, 12'h00F, 5'd1, 5'd2);
        step();
        check("eori_FS", FS, 5'b01100);
        check("eori_sl", status_load, 0);
        instr = mk(10'b1111001000, 12'h010, 5'd1, 5'd2);
        step();
        check("andis_FS", FS, 5'b00000);
        check("andis_sl", status_load, 1);
        check("andis_k", k, 64'h10);
        instr_valid = 1'b0;
        step();
        check("misc_retired", retired, 8);

        // counter wrap: 17 legal consumes after a fresh reset
        reset = 1'b0;
        #1;
        check("wrap_rst_retired", retired, 0);
        check("wrap_rst_retired4", retired4, 0);
        @(negedge clock);
        reset = 1'b1;
        step();
        instr_valid = 1'b1;
        instr       = mk(10'b1001000100, 12'd7, 5'd1, 5'd1);
        for (int i = 0; i < 17; i++) step();
        instr_valid = 1'b0;
        step();
        check("wrap_retired", retired, 17);
        check("wrap_retired4", retired4, 1);

        // 6. async reset while a word is held
        instr_valid = 1'b1;
        instr       = mk(10'b1111000100, 12'd9, 5'd6, 5'd7);
        cw_ready    = 1'b0;
        step();
        instr_valid = 1'b0;
        check("hold_before_rst", state, 1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_cw_valid", cw_valid, 0);
        check("arst_state", state, 0);
        check("arst_DA", DA, 0);
        check("arst_FS", FS, 0);
        check("arst_k", k, 0);
        check("arst_sl", status_load, 0);
        check("arst_retired", retired, 0);
        @(negedge clock);
        reset    = 1'b1;
        cw_ready = 1'b1;
        step();
        step();
        check("arst_discard_retired", retired, 0);
        check("arst_discard_valid", cw_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
